// File: rtl/cam_link_pkg.sv
// CameraLink base-config bit positions and TX FSM state encoding.
// Shared by the TX packer and the RX parser so both agree on the word layout.
package cam_link_pkg;

    typedef enum logic [2:0] {
        ST_VBLANK,
        ST_WAIT_SOF,
        ST_FV_SETUP,
        ST_LINE,
        ST_HBLANK
    } cam_state_t;

    localparam int DVAL_BIT = 26;
    localparam int LVAL_BIT = 24;
    localparam int FVAL_BIT = 25;
    localparam int SPARE_BIT = 23;

    // Port bit n lands on word bit X_MAP[n].
    localparam int A_MAP [8] = '{0, 1, 2, 3, 4, 6, 27, 5};
    localparam int B_MAP [8] = '{7, 8, 9, 12, 13, 14, 10, 11};
    localparam int C_MAP [8] = '{15, 18, 19, 20, 21, 22, 16, 17};

endpackage

// File: rtl/cam_data_packer.sv
// Combinational CameraLink word builder: {dval,lval,fval,A,B,C} -> 28 bits.
// Ports: dval/lval/fval strobes, port_a/b/c pixel bytes, word out.
import cam_link_pkg::*;

module cam_data_packer (
    input  logic        dval,
    input  logic        lval,
    input  logic        fval,
    input  logic [7:0]  port_a,
    input  logic [7:0]  port_b,
    input  logic [7:0]  port_c,
    output logic [27:0] word
);

    logic [27:0] pmap;

    assign pmap[SPARE_BIT] = 1'b0;
    assign pmap[DVAL_BIT]  = 1'b0;
    assign pmap[LVAL_BIT]  = 1'b0;
    assign pmap[FVAL_BIT]  = 1'b0;

    // Pixel bits are gated so the ports read 0 outside valid beats.
    for (genvar i = 0; i < 8; i++) begin : g_map
        assign pmap[A_MAP[i]] = port_a[i] & dval;
        assign pmap[B_MAP[i]] = port_b[i] & dval;
        assign pmap[C_MAP[i]] = port_c[i] & dval;
    end

    always_comb begin
        word = pmap;
        word[DVAL_BIT] = dval;
        word[LVAL_BIT] = lval;
        word[FVAL_BIT] = fval;
    end

endmodule

// File: rtl/cam_tx_axis.sv
// AXI4-Stream video sink regenerating a CameraLink base-config 28-bit word.
// Ports: axis_clk, aresetn (sync, low), s_axis_* sink, cam_data_out, underrun, frame_error.
import cam_link_pkg::*;

module cam_tx_axis #(
    parameter int DATA_WIDTH  = 24,
    parameter int USER_WIDTH  = 1,
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 480,
    parameter int FV_SETUP    = 4,
    parameter int HBLANK      = 8,
    parameter int VBLANK      = 16
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [27:0]           cam_data_out,
    output logic                  underrun,
    output logic                  frame_error
);

    localparam int MAX_FH = (FV_SETUP > HBLANK) ? FV_SETUP : HBLANK;
    localparam int BLANK_MAX = (MAX_FH > VBLANK) ? MAX_FH : VBLANK;
    localparam int PW = $clog2(LINE_PIXELS + 1);
    localparam int LW = $clog2(FRAME_LINES + 1);
    localparam int CW = $clog2(BLANK_MAX + 1);

    cam_state_t state, next_state;

    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [CW-1:0] cyc_cnt;
    logic          sof_first;
    logic          sof;
    logic          accept;
    logic          last_pix;
    logic          line_end;
    logic          len_err;
    logic          early_sof;
    logic          in_line;
    logic          in_frame;
    logic [27:0]   word;

    always_comb begin
        sof = s_axis_tuser[0];
        in_line = (state == ST_LINE);
        in_frame = (state == ST_FV_SETUP) || in_line || (state == ST_HBLANK);
        last_pix = (pix_cnt == PW'(LINE_PIXELS - 1));
        s_axis_tready = 1'b0;
        next_state = state;
        unique case (state)
            ST_VBLANK: begin
                if (cyc_cnt == CW'(VBLANK - 1)) next_state = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                // SoF beat is held back so it becomes the first LINE pixel.
                s_axis_tready = ~sof;
                if (s_axis_tvalid && sof) next_state = ST_FV_SETUP;
            end
            ST_FV_SETUP: begin
                if (cyc_cnt == CW'(FV_SETUP - 1)) next_state = ST_LINE;
            end
            ST_LINE: begin
                s_axis_tready = ~(sof & ~sof_first);
            end
            ST_HBLANK: begin
                if (cyc_cnt == CW'(HBLANK - 1)) next_state = ST_LINE;
            end
            default: next_state = ST_VBLANK;
        endcase
        accept = in_line & s_axis_tvalid & s_axis_tready;
        early_sof = in_line & s_axis_tvalid & sof & ~sof_first;
        line_end = accept & (s_axis_tlast | last_pix);
        len_err = accept & (s_axis_tlast ^ last_pix);
        if (early_sof) begin
            next_state = ST_VBLANK;
        end else if (line_end) begin
            if (line_cnt == LW'(FRAME_LINES - 1)) next_state = ST_VBLANK;
            else next_state = ST_HBLANK;
        end
    end

    cam_data_packer u_packer (
        .dval   (accept),
        .lval   (in_line),
        .fval   (in_frame),
        .port_a (s_axis_tdata[7:0]),
        .port_b (s_axis_tdata[15:8]),
        .port_c (s_axis_tdata[23:16]),
        .word   (word)
    );

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state        <= ST_VBLANK;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            cyc_cnt      <= '0;
            sof_first    <= 1'b0;
            cam_data_out <= '0;
            underrun     <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) cyc_cnt <= '0;
            else if (cyc_cnt != CW'(BLANK_MAX)) cyc_cnt <= cyc_cnt + CW'(1);
            if (!in_line) pix_cnt <= '0;
            else if (accept) pix_cnt <= pix_cnt + PW'(1);
            if (next_state == ST_VBLANK) line_cnt <= '0;
            else if (line_end) line_cnt <= line_cnt + LW'(1);
            if (state == ST_FV_SETUP) sof_first <= 1'b1;
            else if (accept) sof_first <= 1'b0;
            cam_data_out <= word;
            underrun     <= in_line & ~s_axis_tvalid;
            frame_error  <= len_err | early_sof;
        end
    end

endmodule

// File: tb/tb_cam_tx_axis.sv
// Scoreboard bench for cam_tx_axis with a small 4x3 frame geometry.
// Stimulus pushes expected pixels and line lengths; a negedge monitor checks.
module tb_cam_tx_axis;

    localparam int LP = 4;
    localparam int FL = 3;
    localparam int FS = 2;
    localparam int HB = 3;
    localparam int VB = 4;
    localparam logic [27:0] PORT_MASK = 28'h87FFFFF;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [0:0]  tuser;
    logic [27:0] cam_data_out;
    logic        underrun;
    logic        frame_error;

    always #5 clk = ~clk;

    cam_tx_axis #(
        .DATA_WIDTH  (24),
        .USER_WIDTH  (1),
        .LINE_PIXELS (LP),
        .FRAME_LINES (FL),
        .FV_SETUP    (FS),
        .HBLANK      (HB),
        .VBLANK      (VB)
    ) dut (
        .axis_clk      (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .s_axis_tuser  (tuser),
        .cam_data_out  (cam_data_out),
        .underrun      (underrun),
        .frame_error   (frame_error)
    );

    int checks = 0;
    int errors = 0;
    int ur_cnt = 0;
    int fe_cnt = 0;
    logic [23:0] exp_d [$];
    int len_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] ref_pack(input logic [23:0] d);
        int am [8];
        int bm [8];
        int cm [8];
        logic [27:0] w;
        am = '{0, 1, 2, 3, 4, 6, 27, 5};
        bm = '{7, 8, 9, 12, 13, 14, 10, 11};
        cm = '{15, 18, 19, 20, 21, 22, 16, 17};
        w = 28'h7000000;
        for (int i = 0; i < 8; i++) begin
            w[am[i]] = d[i];
            w[bm[i]] = d[8+i];
            w[cm[i]] = d[16+i];
        end
        return w;
    endfunction

    function automatic logic [23:0] rx_parse(input logic [27:0] w);
        int am [8];
        int bm [8];
        int cm [8];
        logic [23:0] d;
        am = '{0, 1, 2, 3, 4, 6, 27, 5};
        bm = '{7, 8, 9, 12, 13, 14, 10, 11};
        cm = '{15, 18, 19, 20, 21, 22, 16, 17};
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[i]    = w[am[i]];
            d[8+i]  = w[bm[i]];
            d[16+i] = w[cm[i]];
        end
        return d;
    endfunction

    // Monitor
    logic prev_lval = 1'b0;
    logic prev_fval = 1'b0;
    bit   first_line = 1'b1;
    int   gap = 0;
    int   pix_run = 0;
    int   fval_low = 0;

    always @(negedge clk) begin
        logic [27:0] w;
        logic [23:0] d;
        logic dv, lv, fv;
        w = cam_data_out;
        if (!$isunknown(w)) begin
            if (underrun === 1'b1) ur_cnt++;
            if (frame_error === 1'b1) fe_cnt++;
            dv = w[26];
            lv = w[24];
            fv = w[25];
            if (dv) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_pixel", {4'h0, w}, 32'h0);
                end else begin
                    d = exp_d.pop_front();
                    check("pixel_word", {4'h0, w}, {4'h0, ref_pack(d)});
                    if (d == 24'hC3A55A) begin
                        check("bitmap_const", {4'h0, w}, 32'h0F07CA9A);
                        check("rx_loopback", {8'h0, rx_parse(w)},
                              32'h00C3A55A);
                    end
                end
            end else begin
                check("idle_ports_zero", {4'h0, w & PORT_MASK}, 32'h0);
            end
            if (fv && !prev_fval) begin
                check("vblank_min", {31'h0, fval_low >= VB}, 32'h1);
            end
            if (!fv) fval_low++;
            else fval_low = 0;
            if (lv) begin
                if (!prev_lval) begin
                    check("lval_gap", gap, first_line ? FS : HB);
                    first_line = 1'b0;
                    pix_run = 0;
                end
                if (dv) pix_run++;
                gap = 0;
            end else begin
                if (prev_lval) begin
                    if (len_q.size() == 0) check("unexpected_line", 32'h1, 32'h0);
                    else check("line_len", pix_run, len_q.pop_front());
                end
                if (fv) gap++;
                else begin
                    gap = 0;
                    first_line = 1'b1;
                end
            end
            prev_lval = lv;
            prev_fval = fv;
        end
    end

    // Stimulus
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic last,
                        input logic user, input bit expect_out);
        bit acc;
        if (expect_out) exp_d.push_back(d);
        tdata  = d;
        tlast  = last;
        tuser  = user;
        tvalid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("handshake_timeout", 32'h0, 32'h1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic send_line(input logic [23:0] base, input int n,
                             input bit with_last, input bit with_sof);
        len_q.push_back(n);
        for (int i = 0; i < n; i++)
            send(base + 24'(i), with_last && (i == n - 1),
                 with_sof && (i == 0), 1'b1);
    endtask

    task automatic send_frame(input logic [23:0] base);
        send_line(base, LP, 1'b1, 1'b1);
        send_line(base + 24'h100, LP, 1'b1, 1'b0);
        send_line(base + 24'h200, LP, 1'b1, 1'b0);
    endtask

    int ur0, fe0;

    initial begin
        aresetn = 1'b0;
        tdata   = '0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tuser   = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        check("reset_word", {4'h0, cam_data_out}, 32'h0);
        check("reset_underrun", {31'h0, underrun}, 32'h0);
        check("reset_frame_error", {31'h0, frame_error}, 32'h0);
        check("reset_tready", {31'h0, tready}, 32'h0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Junk beats before SoF are dropped, then a clean frame.
        for (int i = 0; i < 3; i++) send(24'hBAD000 + 24'(i), 1'b0, 1'b0, 1'b0);
        ur0 = ur_cnt;
        fe0 = fe_cnt;
        send_line(24'hC3A55A, LP, 1'b1, 1'b1);
        send_line(24'h111100, LP, 1'b1, 1'b0);
        send_line(24'h222200, LP, 1'b1, 1'b0);
        wait_cycles(10);
        check("clean_underrun", ur_cnt - ur0, 0);
        check("clean_frame_error", fe_cnt - fe0, 0);

        // Two idle cycles mid-line.
        ur0 = ur_cnt;
        fe0 = fe_cnt;
        len_q.push_back(LP);
        send(24'h300000, 1'b0, 1'b1, 1'b1);
        send(24'h300001, 1'b0, 1'b0, 1'b1);
        wait_cycles(2);
        send(24'h300002, 1'b0, 1'b0, 1'b1);
        send(24'h300003, 1'b1, 1'b0, 1'b1);
        send_line(24'h300100, LP, 1'b1, 1'b0);
        send_line(24'h300200, LP, 1'b1, 1'b0);
        wait_cycles(10);
        check("gap_underrun", ur_cnt - ur0, 2);
        check("gap_frame_error", fe_cnt - fe0, 0);

        // Short line with tlast, then a forced close without tlast.
        ur0 = ur_cnt;
        fe0 = fe_cnt;
        send_line(24'h400000, 3, 1'b1, 1'b1);
        send_line(24'h400100, LP, 1'b0, 1'b0);
        send_line(24'h400200, LP, 1'b1, 1'b0);
        wait_cycles(10);
        check("len_frame_error", fe_cnt - fe0, 2);
        check("len_underrun", ur_cnt - ur0, 0);

        // Early SoF on line 2 restarts the frame with that pixel.
        fe0 = fe_cnt;
        send_line(24'h500000, LP, 1'b1, 1'b1);
        len_q.push_back(0);
        len_q.push_back(LP);
        send(24'h600000, 1'b0, 1'b1, 1'b1);
        send(24'h600001, 1'b0, 1'b0, 1'b1);
        send(24'h600002, 1'b0, 1'b0, 1'b1);
        send(24'h600003, 1'b1, 1'b0, 1'b1);
        send_line(24'h600100, LP, 1'b1, 1'b0);
        send_line(24'h600200, LP, 1'b1, 1'b0);
        wait_cycles(10);
        check("early_sof_frame_error", fe_cnt - fe0, 1);

        // Reset in the middle of a line.
        len_q.push_back(2);
        send(24'h700000, 1'b0, 1'b1, 1'b1);
        send(24'h700001, 1'b0, 1'b0, 1'b1);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        check("midline_reset_word", {4'h0, cam_data_out}, 32'h0);
        check("midline_reset_underrun", {31'h0, underrun}, 32'h0);
        wait_cycles(2);
        aresetn = 1'b1;
        wait_cycles(12);
        check("pixels_drained", exp_d.size(), 0);
        check("lines_drained", len_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
